// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Purpose : bundles the byte-stream handshake and the instruction-memory
//           write port used by imem_loader.
// Signals : byte_valid / byte_data  - stream byte offered by the host side
//           byte_ready              - loader accepts the offered byte
//           mem_we                  - one-cycle write strobe per word
//           mem_addr                - word-aligned byte address of the write
//           mem_wdata               - assembled little-endian word
// Modports: master - the loader (consumes bytes, drives the memory port)
//           slave  - the environment (byte source and memory)
// ---------------------------------------------------------------------------
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Purpose : receives a program as a byte stream (16-bit little-endian word
//           count followed by 4 bytes per word), assembles little-endian
//           32-bit words and writes them into the instruction memory while
//           holding the CPU.
// Ports   : clk           - system clock, rising edge
//           reset_n       - asynchronous active-low reset
//           start         - one-cycle pulse, begins a load when not busy
//           bus           - byte stream in / memory write port out
//           cpu_hold      - keep CPU stalled while loading or after an error
//           busy          - load in progress
//           done          - last load finished cleanly, held until next start
//           error         - word count exceeded memory depth, held until start
//           words_written - words written by the current / last load
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  imem_loader_if.master         bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal word count; 17 bits so a full 16-bit length compares cleanly.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                byte_ready_q, byte_ready_d;
  logic                busy_q, busy_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic [15:0]         len_full;

  assign accept   = bus.byte_valid && byte_ready_q;
  assign len_full = {bus.byte_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    lane_d      = lane_q;
    word_d      = word_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          count_d = '0;
          lane_d  = '0;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bus.byte_data;
          state_d    = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.byte_data;
          lane_d      = '0;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, len_full} > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          word_d[{lane_q, 3'b000} +: 8] = bus.byte_data;
          lane_d = lane_q + 2'd1;
          // The 4th byte completes the word; latch the write now so the
          // memory port is driven straight from flops during WRITE.
          if (lane_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_wdata_d = word_d;
            mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
          end
        end
      end

      S_WRITE: begin
        count_d = count_q + 1'b1;
        if (17'(count_q) + 17'd1 == {1'b0, len_q}) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they are registered
    // and line up with the state they describe.
    mem_we_d     = (state_d == S_WRITE);
    byte_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
    busy_d       = byte_ready_d || (state_d == S_WRITE);
    hold_d       = busy_d || (state_d == S_ERR);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      count_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      count_q      <= count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_hold       = hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_written  = count_q;

endmodule
